lcd_frame_scheduler: RTL
========================

# lcd_frame_scheduler

Frame scheduler for the 8-bit 8080-style ILI9341 write bus. It runs after the init sequence has completed and waits for a tearing-effect (FMARK) edge. It then issues the column/page window commands and a Memory Write, and streams WIDTH×HEIGHT RGB565 pixels from an upstream source using a valid/ready handshake. It owns o_lcd_data/o_lcd_rs/o_lcd_wr while enabled.

## Interface
- WIDTH, 320, pixels per line (1..511)
- HEIGHT, 240, lines per frame (1..511)
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  level; 1 = schedule frames, sampled only in IDLE and at frame end
- i_lcd_fmark  in  1  panel TE output, asynchronous
- i_pix_data  in  16  RGB565 pixel
- i_pix_valid  in  1  pixel available
- o_pix_ready  out  1  scheduler accepts pixel this cycle
- o_lcd_data  out  8  bus data
- o_lcd_rs  out  1  0 = command, 1 = data
- o_lcd_wr  out  1  write strobe, active low; panel latches on rising edge
- o_busy  out  1  1 from first command byte to last pixel byte
- o_frame_done  out  1  one-cycle pulse after last pixel byte latched
- o_te_miss  out  1  one-cycle pulse on FMARK edge seen while busy

## Operation
- FMARK is passed through a 2-flop synchroniser plus a history flop. te_edge = sync & ~hist.
- Byte write primitive is 2 cycles: SETUP cycle drives data and rs with wr=0, then LATCH cycle drives wr=1 with data and rs held.
- Command list, 11 bytes, in order (rs in brackets):
  - 2A[0], 00[1], 00[1], (WIDTH-1)[15:8][1], (WIDTH-1)[7:0][1]
  - 2B[0], 00[1], 00[1], (HEIGHT-1)[15:8][1], (HEIGHT-1)[7:0][1]
  - 2C[0]
- States:
  - IDLE: if i_enable → WAIT_TE.
  - WAIT_TE: on te_edge → CMD_SETUP with cmd index 0. If i_enable=0 → IDLE.
  - CMD_SETUP → CMD_LATCH.
  - CMD_LATCH: if index==10 → PIX_WAIT with x=y=0; else index+1 → CMD_SETUP.
  - PIX_WAIT: o_pix_ready=1, wr=1. On valid&ready, capture pixel → PIX_HI_SETUP.
  - PIX_HI_SETUP (data = pixel[15:8], rs=1, wr=0) → PIX_HI_LATCH → PIX_LO_SETUP (pixel[7:0], wr=0) → PIX_LO_LATCH.
  - PIX_LO_LATCH: if x==WIDTH-1 and y==HEIGHT-1, pulse o_frame_done and go to WAIT_TE if i_enable, else IDLE. Otherwise x+1 (wraps to 0 with y+1 at WIDTH-1) → PIX_WAIT.
- The high byte is sent first.
- Pixel underflow (valid=0 in PIX_WAIT) stalls with wr=1 indefinitely. No bytes are dropped or repeated.
- o_pix_ready is 1 only in PIX_WAIT. It is a registered output.
- te_edge outside WAIT_TE while o_busy=1 pulses o_te_miss and is otherwise ignored. It never restarts a frame.
- Deasserting i_enable mid-frame has no effect until frame end.
- x and y counters are 9 bits, compared against WIDTH-1 and HEIGHT-1. They never exceed those limits.

## Timing
- Reset values: state IDLE, o_lcd_wr=1, o_lcd_rs=1, o_lcd_data=00, o_pix_ready=0, o_busy=0, o_frame_done=0, o_te_miss=0, counters 0, synchroniser flops 0.
- Reset applied mid-frame returns every register to its reset value on that edge. A new frame requires a fresh FMARK edge.
- FMARK rise to te_edge: 2–3 clocks (synchroniser).
- te_edge to first wr=0 (2A): 1 clock.
- Command phase: 22 clocks.
- Pixel throughput at continuous valid: 5 clocks/pixel (WAIT, HI_S, HI_L, LO_S, LO_L).
- Frame length = 22 + 5·WIDTH·HEIGHT clocks with no stalls.
- o_frame_done is asserted the cycle after the final LO_LATCH. o_busy falls in the same cycle.
- All outputs are registered. o_lcd_data and o_lcd_rs are stable for the whole SETUP+LATCH pair.

## Test plan
- Window bytes: WIDTH=4, HEIGHT=2, single FMARK pulse → the bus monitor captures rs/data sequence 0:2A,1:00,1:00,1:00,1:03,0:2B,1:00,1:00,1:00,1:01,0:2C. wr is low exactly 1 clock per byte.
- Pixel order: WIDTH=4, HEIGHT=2, source supplies 16'h1234 + n for n=0..7 with valid held high → data bytes 12,34,12,35,…,12,3B. o_frame_done pulses once, exactly 22+40 clocks after the first wr=0.
- Underflow: drop valid for 7 clocks after pixel 3 → wr stays high for the whole gap, o_pix_ready stays 1, no duplicate bytes, byte stream identical to the previous test.
- TE during frame: second FMARK edge mid-pixel-stream → one o_te_miss pulse, stream continues uninterrupted. The next frame starts only on the following FMARK edge.
- Enable/idle: i_enable=0 with FMARK toggling → no wr=0 ever, o_busy=0. Drop i_enable mid-frame → the frame completes, then the block returns to IDLE.
- Reset mid-command (during byte 2B) → next cycle o_lcd_wr=1, o_lcd_rs=1, data=00, o_busy=0. The next FMARK restarts from 2A.

Source files
------------

// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler
// Waits for a tearing-effect edge, then writes the column/page window and
// Memory Write commands to an 8080-style ILI9341 bus and streams
// WIDTH x HEIGHT RGB565 pixels (high byte first) from a valid/ready source.
// Every output is registered: the next-cycle bus values are derived from the
// next state and loaded together with it.
module lcd_frame_scheduler #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_lcd_fmark,
  input  logic [15:0] i_pix_data,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_wr,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_te_miss
);

  localparam logic [15:0] W_LAST_16 = 16'(WIDTH - 1);
  localparam logic [15:0] H_LAST_16 = 16'(HEIGHT - 1);
  localparam logic [8:0]  X_LAST    = 9'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST    = 9'(HEIGHT - 1);
  localparam logic [3:0]  CMD_LAST  = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WAIT_TE      = 4'd1,
    ST_CMD_SETUP    = 4'd2,
    ST_CMD_LATCH    = 4'd3,
    ST_PIX_WAIT     = 4'd4,
    ST_PIX_HI_SETUP = 4'd5,
    ST_PIX_HI_LATCH = 4'd6,
    ST_PIX_LO_SETUP = 4'd7,
    ST_PIX_LO_LATCH = 4'd8
  } state_t;

  // Window/command byte for a given position in the 11-byte command list.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h2A;
      4'd3:    b = W_LAST_16[15:8];
      4'd4:    b = W_LAST_16[7:0];
      4'd5:    b = 8'h2B;
      4'd8:    b = H_LAST_16[15:8];
      4'd9:    b = H_LAST_16[7:0];
      4'd10:   b = 8'h2C;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Command opcodes go out with rs=0, their parameters with rs=1.
  function automatic logic cmd_rs(input logic [3:0] idx);
    logic r;
    case (idx)
      4'd0, 4'd5, 4'd10: r = 1'b0;
      default:           r = 1'b1;
    endcase
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [8:0]  x_r, x_s;
  logic [8:0]  y_r, y_s;
  logic [15:0] pix_r, pix_s;
  logic [7:0]  data_r, data_s;
  logic        rs_r, rs_s;
  logic        wr_r, wr_s;
  logic        ready_r, ready_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        miss_r, miss_s;
  logic        fmark_meta_r, fmark_sync_r, fmark_hist_r;
  logic        te_edge_s;

  assign te_edge_s = fmark_sync_r & ~fmark_hist_r;

  // Synchronise the asynchronous FMARK input and keep one flop of history for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fmark_meta_r <= 1'b0;
      fmark_sync_r <= 1'b0;
      fmark_hist_r <= 1'b0;
    end else begin
      fmark_meta_r <= i_lcd_fmark;
      fmark_sync_r <= fmark_meta_r;
      fmark_hist_r <= fmark_sync_r;
    end
  end

  // Next-state, counter and pixel-capture logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    x_s     = x_r;
    y_s     = y_r;
    pix_s   = pix_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          state_s = ST_WAIT_TE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_TE: begin
        if (!i_enable) begin
          state_s = ST_IDLE;
        end else if (te_edge_s) begin
          state_s = ST_CMD_SETUP;
          idx_s   = 4'd0;
        end else begin
          state_s = ST_WAIT_TE;
        end
      end
      ST_CMD_SETUP: begin
        state_s = ST_CMD_LATCH;
      end
      ST_CMD_LATCH: begin
        if (idx_r == CMD_LAST) begin
          state_s = ST_PIX_WAIT;
          x_s     = 9'd0;
          y_s     = 9'd0;
        end else begin
          state_s = ST_CMD_SETUP;
          idx_s   = idx_r + 4'd1;
        end
      end
      ST_PIX_WAIT: begin
        if (i_pix_valid && ready_r) begin
          state_s = ST_PIX_HI_SETUP;
          pix_s   = i_pix_data;
        end else begin
          state_s = ST_PIX_WAIT;
        end
      end
      ST_PIX_HI_SETUP: begin
        state_s = ST_PIX_HI_LATCH;
      end
      ST_PIX_HI_LATCH: begin
        state_s = ST_PIX_LO_SETUP;
      end
      ST_PIX_LO_SETUP: begin
        state_s = ST_PIX_LO_LATCH;
      end
      ST_PIX_LO_LATCH: begin
        if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
          done_s = 1'b1;
          x_s    = 9'd0;
          y_s    = 9'd0;
          if (i_enable) begin
            state_s = ST_WAIT_TE;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (x_r == X_LAST) begin
          x_s     = 9'd0;
          y_s     = y_r + 9'd1;
          state_s = ST_PIX_WAIT;
        end else begin
          x_s     = x_r + 9'd1;
          state_s = ST_PIX_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus values for the coming cycle; data and rs hold through each LATCH and wait cycle.
  always_comb begin
    data_s  = data_r;
    rs_s    = rs_r;
    wr_s    = 1'b1;
    ready_s = 1'b0;
    busy_s  = 1'b1;
    case (state_s)
      ST_IDLE, ST_WAIT_TE: begin
        busy_s = 1'b0;
      end
      ST_CMD_SETUP: begin
        data_s = cmd_byte(idx_s);
        rs_s   = cmd_rs(idx_s);
        wr_s   = 1'b0;
      end
      ST_PIX_WAIT: begin
        ready_s = 1'b1;
      end
      ST_PIX_HI_SETUP: begin
        data_s = pix_s[15:8];
        rs_s   = 1'b1;
        wr_s   = 1'b0;
      end
      ST_PIX_LO_SETUP: begin
        data_s = pix_s[7:0];
        rs_s   = 1'b1;
        wr_s   = 1'b0;
      end
      default: begin
        wr_s = 1'b1;
      end
    endcase
    miss_s = te_edge_s & busy_r;
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      x_r     <= 9'd0;
      y_r     <= 9'd0;
      pix_r   <= 16'h0000;
      data_r  <= 8'h00;
      rs_r    <= 1'b1;
      wr_r    <= 1'b1;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      miss_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      x_r     <= x_s;
      y_r     <= y_s;
      pix_r   <= pix_s;
      data_r  <= data_s;
      rs_r    <= rs_s;
      wr_r    <= wr_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      miss_r  <= miss_s;
    end
  end

  assign o_pix_ready  = ready_r;
  assign o_lcd_data   = data_r;
  assign o_lcd_rs     = rs_r;
  assign o_lcd_wr     = wr_r;
  assign o_busy       = busy_r;
  assign o_frame_done = done_r;
  assign o_te_miss    = miss_r;

endmodule
